// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences imem req/ack, applies branches and stalls,
// and absorbs a late fetch in a one-entry skid buffer. Optional watchdog: `define FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_offset_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              instr_valid_o,
    output logic              fetch_error_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              drop_q, drop_d;
    logic              req_q, req_d;

    logic              consume_s;
    logic              branch_s;
    logic              ack_s;
    logic [ADDR_W-1:0] target_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Next-state, datapath and handshake decisions for the whole fetch stage.
    always_comb begin
        consume_s = valid_q && !stall_i;
        branch_s  = consume_s && branch_taken_i;
        ack_s     = req_q && imem_ack_i;
        target_s  = pc_q + PC_STEP + (branch_offset_i << 2);

        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        redirect_d   = redirect_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        drop_d       = drop_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                // The skid buffer is always empty here; it only fills on the way into HOLD.
                if (branch_s) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    if (ack_s) begin
                        fetch_pc_d = target_s;
                    end else begin
                        drop_d     = 1'b1;
                        redirect_d = target_s;
                    end
                end else if (ack_s && drop_q) begin
                    drop_d     = 1'b0;
                    fetch_pc_d = redirect_q;
                end else if (ack_s) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    if (!valid_q || consume_s) begin
                        instr_d = imem_rdata_i;
                        pc_d    = fetch_pc_q;
                        valid_d = 1'b1;
                    end else begin
                        skid_instr_d = imem_rdata_i;
                        skid_pc_d    = fetch_pc_q;
                        skid_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end else if (consume_s) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            ST_HOLD: begin
                if (branch_s) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    fetch_pc_d   = target_s;
                    state_d      = ST_REQ;
                end else if (consume_s) begin
                    instr_d      = skid_instr_q;
                    pc_d         = skid_pc_q;
                    valid_d      = 1'b1;
                    skid_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_ERR: begin
                valid_d = 1'b0;
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef FETCH_TIMEOUT_EN
        cnt_d = cnt_q;
        err_d = err_q;
        if (req_q && !imem_ack_i) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
            if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
                state_d      = ST_ERR;
                valid_d      = 1'b0;
                skid_valid_d = 1'b0;
                drop_d       = 1'b0;
                err_d        = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else if (ack_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end
`endif

        req_d = (state_d == ST_REQ);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            redirect_q   <= RESET_PC;
            instr_q      <= {DATA_W{1'b0}};
            pc_q         <= {ADDR_W{1'b0}};
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= {DATA_W{1'b0}};
            skid_pc_q    <= {ADDR_W{1'b0}};
            drop_q       <= 1'b0;
            req_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q        <= {CNT_W{1'b0}};
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            redirect_q   <= redirect_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            drop_q       <= drop_d;
            req_q        <= req_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_error_o = err_q;
`else
    assign fetch_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios push expected PCs, a monitor checks
// every instruction decode accepts. Memory returns (addr ^ TAG) after mem_lat wait cycles.
module tb_fetch_sequencer;
    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam logic [31:0] TAG = 32'hA500_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_i;
    logic          branch_taken_i;
    logic [AW-1:0] branch_offset_i;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_ack_i;
    logic [DW-1:0] imem_rdata_i;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] pc_o;
    logic          instr_valid_o;
    logic          fetch_error_o;

    int            checks   = 0;
    int            failures = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] mon_exp;
    int            mem_lat   = 0;
    int            mem_cnt   = 0;
    logic [AW-1:0] mem_limit = 32'h0000_0000;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_offset_i(branch_offset_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .instr_valid_o  (instr_valid_o),
        .fetch_error_o  (fetch_error_o)
    );

    always #5 clk = ~clk;

    // Memory model: addresses at or above mem_limit are never acknowledged.
    assign imem_ack_i   = imem_req_o && (mem_cnt >= mem_lat) && (imem_addr_o < mem_limit);
    assign imem_rdata_i = imem_addr_o ^ TAG;

    always @(posedge clk) begin
        if (rst || !imem_req_o || imem_ack_i) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every instruction accepted by decode must be the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && instr_valid_o && !stall_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got pc %0h, want none", pc_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_pc", {32'h0, pc_o}, {32'h0, mon_exp});
                check("sb_instr", {32'h0, instr_o}, {32'h0, mon_exp ^ TAG});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_offset_i = 32'h0000_0000;
        tick();
        tick();
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (4) tick();
    endtask

    task automatic wait_pc(input string name, input logic [AW-1:0] pc, input int budget);
        int n = 0;
        while (!(instr_valid_o && pc_o == pc) && n < budget) begin
            tick();
            n++;
        end
        check(name, {63'h0, instr_valid_o && pc_o == pc}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {63'h0, imem_req_o},    64'd0);
        check({tag, "_addr"},  {32'h0, imem_addr_o},   64'd0);
        check({tag, "_valid"}, {63'h0, instr_valid_o}, 64'd0);
        check({tag, "_instr"}, {32'h0, instr_o},       64'd0);
        check({tag, "_pc"},    {32'h0, pc_o},          64'd0);
        check({tag, "_err"},   {63'h0, fetch_error_o}, 64'd0);
    endtask

    initial begin
        int n;
        do_reset();
        check_reset_outputs("rst");

        // Zero-wait memory: back-to-back delivery 0,4,8,12.
        mem_lat = 0; mem_limit = 32'h10;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        rst = 1'b0;
        tick();
        check("t1_idle_valid", {63'h0, instr_valid_o}, 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", {63'h0, instr_valid_o}, 64'd1);
            check("t1_pc", {32'h0, pc_o}, 64'(i * 4));
            tick();
        end
        drain("t1_drain", 20);
        do_reset();

        // Three wait states: stable address, single-cycle valid then bubble.
        mem_lat = 3; mem_limit = 32'h0C;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
        rst = 1'b0;
        n = 0;
        while (!imem_req_o && n < 10) begin tick(); n++; end
        n = 0;
        while (imem_req_o && !imem_ack_i && n < 10) begin
            check("t2_addr_stable", {32'h0, imem_addr_o}, 64'd0);
            n++;
            tick();
        end
        check("t2_wait_cycles", 64'(n), 64'd3);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!instr_valid_o && n < 20) begin tick(); n++; end
            check("t2_found", {63'h0, instr_valid_o}, 64'd1);
            tick();
            check("t2_bubble", {63'h0, instr_valid_o}, 64'd0);
        end
        drain("t2_drain", 40);
        do_reset();

        // Stall with an ack during it: skid holds pc 8, no requests while full.
        mem_lat = 0; mem_limit = 32'h18;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        rst = 1'b0;
        wait_pc("t3_reach4", 32'h4, 20);
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_hold_pc", {32'h0, pc_o}, 64'h4);
            check("t3_hold_valid", {63'h0, instr_valid_o}, 64'd1);
            check("t3_no_req", {63'h0, imem_req_o}, 64'd0);
        end
        stall_i = 1'b0;
        tick();
        check("t3_skid_pc", {32'h0, pc_o}, 64'h8);
        check("t3_skid_valid", {63'h0, instr_valid_o}, 64'd1);
        drain("t3_drain", 40);
        do_reset();

        // Branch at 0x10 with offset -2 while 0x14 is in flight: 0x14 dropped, refetch 0x0C.
        mem_lat = 2; mem_limit = 32'h18;
        exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h0C, 32'h10, 32'h14};
        rst = 1'b0;
        wait_pc("t4_reach10", 32'h10, 40);
        check("t4_inflight_req", {63'h0, imem_req_o}, 64'd1);
        check("t4_inflight_addr", {32'h0, imem_addr_o}, 64'h14);
        check("t4_inflight_noack", {63'h0, imem_ack_i}, 64'd0);
        branch_taken_i  = 1'b1;
        branch_offset_i = 32'hFFFF_FFFE;
        tick();
        branch_taken_i  = 1'b0;
        branch_offset_i = 32'h0000_0000;
        check("t4_flush", {63'h0, instr_valid_o}, 64'd0);
        n = 0;
        while (!(imem_ack_i && imem_addr_o == 32'h14) && n < 20) begin tick(); n++; end
        check("t4_drop_ack_seen", {63'h0, imem_ack_i}, 64'd1);
        tick();
        check("t4_next_req", {63'h0, imem_req_o}, 64'd1);
        check("t4_next_addr", {32'h0, imem_addr_o}, 64'h0C);
        check("t4_dropped_not_shown", {63'h0, instr_valid_o}, 64'd0);
        drain("t4_drain", 60);
        do_reset();

        // Reset in the middle of a wait, then restart at RESET_PC.
        mem_lat = 5; mem_limit = 32'h04;
        exp_q = '{32'h00, 32'h00};
        rst = 1'b0;
        wait_pc("t5_first", 32'h0, 30);
        tick();
        tick();
        check("t5_in_wait", {63'h0, imem_req_o}, 64'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("t5_rst");
        rst = 1'b0;
        n = 0;
        while (!imem_req_o && n < 10) begin tick(); n++; end
        check("t5_first_req", {32'h0, imem_addr_o}, 64'd0);
        drain("t5_drain", 30);
        do_reset();

        // Memory that never answers.
        mem_lat = 0; mem_limit = 32'h0;
        rst = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        check("t6_err_early", {63'h0, fetch_error_o}, 64'd0);
        tick();
        check("t6_err_set", {63'h0, fetch_error_o}, 64'd1);
        check("t6_err_noreq", {63'h0, imem_req_o}, 64'd0);
        check("t6_err_novalid", {63'h0, instr_valid_o}, 64'd0);
        repeat (5) tick();
        check("t6_err_sticky", {63'h0, fetch_error_o}, 64'd1);
        rst = 1'b1;
        tick();
        check("t6_err_cleared", {63'h0, fetch_error_o}, 64'd0);
`else
        repeat (40) tick();
        check("t6_no_err", {63'h0, fetch_error_o}, 64'd0);
        check("t6_still_req", {63'h0, imem_req_o}, 64'd1);
        check("t6_still_addr", {32'h0, imem_addr_o}, 64'd0);
`endif
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller for the instruction-fetch stage. It owns the program counter and sequences requests to a variable-latency instruction memory through a req/ack handshake. It applies branch redirects and decode-stage stalls, and presents one instruction at a time to decode through a valid/stall interface. A one-entry skid buffer absorbs a fetch that completes while decode is stalled.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
DATA_W, 32, instruction width
RESET_PC, 0, first fetch address after reset
MEM_TIMEOUT, 15, maximum wait cycles for imem_ack_i; used only with FETCH_TIMEOUT_EN

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall_i  in  1  decode not accepting; holds instr_o/pc_o
branch_taken_i  in  1  branch resolved for the instruction currently on instr_o
branch_offset_i  in  ADDR_W  sign-extended word offset
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  byte address of the request
imem_ack_i  in  1  request complete; imem_rdata_i valid this cycle
imem_rdata_i  in  DATA_W  fetched instruction
instr_o  out  DATA_W  instruction to decode
pc_o  out  ADDR_W  byte address of instr_o
instr_valid_o  out  1  instr_o/pc_o valid
fetch_error_o  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; fetch_pc=RESET_PC; instr_o=0; pc_o=0; instr_valid_o=0; imem_req_o=0; imem_addr_o=RESET_PC; skid empty; drop flag=0; fetch_error_o=0. The instruction memory shares rst and aborts any outstanding transaction.
- States:
  - IDLE -> REQ: one cycle after rst deasserts.
  - REQ/WAIT: imem_req_o=1 and imem_addr_o=fetch_pc, both held stable until imem_ack_i is sampled 1. Ack may arrive in the same cycle as the first req cycle, giving zero wait states.
  - On ack, at most one outstanding request: fetch_pc += 4. The next request issues on the following cycle unless the skid buffer is full, in which case go to HOLD.
  - HOLD: imem_req_o=0 until the skid buffer drains, then back to REQ.
- Delivery on ack, with drop=0:
  - Output slot empty, or (instr_valid_o=1 and stall_i=0): instr_o<=rdata, pc_o<=address, instr_valid_o<=1.
  - Otherwise (stalled and full): write rdata and address into the skid buffer.
- Consumption: when instr_valid_o=1 and stall_i=0, the slot is consumed.
  - If the skid buffer is full, it moves into the slot in the same cycle.
  - Otherwise, an ack arriving that cycle refills the slot.
  - Otherwise instr_valid_o<=0.
- Branch: honoured only when instr_valid_o=1, stall_i=0 and branch_taken_i=1.
  - target = pc_o + 4 + (branch_offset_i << 2), modulo 2^ADDR_W (wraps, no overflow flag).
  - Next cycle: instr_valid_o=0, skid cleared, fetch_pc=target.
  - If a request is outstanding and not acked in the branch cycle, set drop=1. The next ack is discarded and drop is cleared, then the request to target issues.
  - If the ack arrives in the branch cycle itself, its data is discarded, with no drop needed.
  - A new request to target otherwise issues the cycle after the branch.
- Simultaneous events:
  - Branch beats a same-cycle ack.
  - rst beats everything.
  - branch_taken_i is ignored while stall_i=1 or instr_valid_o=0.
- PC increments wrap modulo 2^ADDR_W.

Optional Feature:
FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on each new request and increments each cycle that imem_req_o=1 and imem_ack_i=0.
  - When the counter reaches MEM_TIMEOUT, enter ERR: imem_req_o=0, instr_valid_o=0, fetch_error_o=1.
  - ERR persists until rst.
- Undefined: no counter; the block waits indefinitely; fetch_error_o is tied 0.

Test Plan:
- Zero-wait memory (ack same cycle as req), stall_i=0 -> pc_o sequence 0,4,8,12 on consecutive cycles after the first; instr_valid_o stays 1.
- Ack latency 3 cycles -> imem_addr_o stable for 3 cycles; each instruction is valid 1 cycle, followed by bubbles; pc_o=0,4,8.
- stall_i=1 for 4 cycles, with an ack arriving during the stall -> instr_o held; skid captures pc 8; no req while skid is full. On release, pc 8 is presented the next cycle with no loss or duplication.
- Branch at pc_o=0x10, offset=-2 (0xFFFFFFFE) with a fetch of 0x14 in flight -> 0x14 data dropped; next request 0x0C; pc_o=0x0C is the next valid output.
- rst asserted mid-WAIT -> all outputs return to reset values next edge; first request after release is at RESET_PC.
- FETCH_TIMEOUT_EN defined, ack never returned, MEM_TIMEOUT=15 -> fetch_error_o=1 after 15 wait cycles; imem_req_o=0; flag remains 1 until rst.
